sr_cmd_gen: RTL and testbench
=============================

# sr_cmd_gen

Command front-end for the lab SR flip-flop stage. It takes two raw, asynchronous pushbutton inputs (set and clear), then synchronises and debounces them. It converts each debounced press into a single-cycle `S` or `R` pulse that drives the flip-flop's `S`/`R` inputs directly. It never drives `S` and `R` high together, so the flip-flop's undefined S=R=1 case cannot occur. It also issues an initialising `R` pulse after reset, because the flip-flop itself has no reset.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles a synchronised input must differ from its debounced value before the debounced value changes. Legal range is ≥1; board builds override it (e.g. 1_000_000).
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: width of each debounce counter.
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: reset, synchronous, active-low. All state is cleared on a `clk` edge while low.
- `btn_set`, input, 1: raw set button, asynchronous, active-high.
- `btn_clr`, input, 1: raw clear button, asynchronous, active-high.
- `S`, output, 1: set pulse to the flip-flop, one cycle wide.
- `R`, output, 1: reset pulse to the flip-flop, one cycle wide.
- `conflict`, output, 1: one-cycle flag; both presses qualified on the same edge and both were dropped.
- `sr_state`, output, 1: expected flip-flop `Q`, tracked from the issued pulses.

## Operation
- Per channel (set, clear), the pipeline has four stages:
  - two-flop synchroniser `s1` → `s2`;
  - debounced level `db` with counter `cnt`;
  - delayed copy `db_d`;
  - press event = `db & ~db_d`, which is rising edges only; releases generate nothing.
- Debounce rule, each edge:
  - if `s2 == db`, then `cnt <= 0`;
  - else if `cnt == DEBOUNCE_CYCLES-1`, then `db <= s2` and `cnt <= 0`;
  - else `cnt <= cnt+1`.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles at `s2` never changes `db`.
- Control FSM, with states:
  - `INIT`: entered on any edge with `rst_n=0`. On the first edge with `rst_n=1`, the block registers `R=1` and moves to `RUN`.
  - `RUN`: the block registers the following outputs each edge:
    - `S <= set_evt & ~clr_evt`;
    - `R <= clr_evt & ~set_evt`;
    - `conflict <= set_evt & clr_evt`.
- `sr_state` updates on the edge after a pulse is visible:
  - set to 1 when `S=1`;
  - cleared to 0 when `R=1`;
  - otherwise holds.
  - It therefore matches the flip-flop `Q`, which latches `S`/`R` on the same `clk` edge.
- Invariant: `S & R` is 0 in every cycle, including the INIT cycle.
- Holding a button produces exactly one pulse. A new pulse requires `db` to return to 0, which needs `DEBOUNCE_CYCLES` cycles low, and then rise again.

## Timing
- Reset values, on every edge with `rst_n=0`:
  - `S=0`, `R=0`, `conflict=0`, `sr_state=0`;
  - all `s1`, `s2`, `db`, `db_d`, `cnt` are 0;
  - FSM is in `INIT`.
- Init pulse:
  - `R=1` in the cycle after the first edge with `rst_n=1`, for exactly one cycle;
  - `sr_state` stays 0.
  - Debouncers start from 0, so no press can coincide with the init pulse.
- Press latency. Take E0 as the first edge sampling `btn_set=1`, with the input held stable:
  - `s2=1` after E1;
  - `db=1` after E(1+D), where D=`DEBOUNCE_CYCLES`;
  - `S=1` after E(2+D) for one cycle;
  - `sr_state=1` after E(3+D).
- Release latency mirrors press latency with no output pulse.
- Simultaneous events:
  - Same-edge set and clear events give `S=R=0` and `conflict=1` for one cycle; `sr_state` is unchanged.
  - Events on different edges are each honoured in order, even on adjacent cycles.
- Reset mid-operation:
  - Pending counts, pulses, and `sr_state` clear on the reset edge.
  - A button still held at release must be re-debounced from 0 and then produces one press pulse after the init `R` pulse.
- The counter never exceeds `DEBOUNCE_CYCLES-1`; there is no wrap-around.

## Test plan
- Reset release, D=4: hold `rst_n=0` for 3 edges, then 1 → `R=1` for exactly the first cycle after release; `S=0`, `conflict=0`, `sr_state=0` throughout.
- Clean press, D=4: raise `btn_set` at E0 and hold 20 cycles → single `S` pulse after E6; `sr_state=1` from E7 on; no further pulses while held.
- Bounce rejection, D=4: toggle `btn_clr` 1,0,1,0 with 3-cycle widths, then hold 1 → no pulse during bouncing; one `R` pulse 6 edges after the final stable rising sample; `sr_state` goes 1→0.
- Simultaneous press, D=4: raise `btn_set` and `btn_clr` on the same edge → `conflict=1` for one cycle, `S=R=0` throughout, `sr_state` unchanged. Then release both, wait 10 cycles, press set alone → normal `S` pulse.
- Reset mid-debounce: hold `btn_set` and assert `rst_n=0` when `cnt=2`, release after 2 edges with the button still held → init `R` pulse, then `S` pulse D+2 edges after the first post-reset sample; `sr_state` ends at 1.
- Invariant check: random button stimulus for 10k cycles with D=1 and D=7 → `S&R` never 1, every pulse is one cycle wide, and `sr_state` always equals a reference model of the flip-flop `Q`.

Source files
------------

// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: pushbutton front-end for the lab SR flip-flop stage.
// Two raw buttons (set, clear) are synchronised and debounced, and each
// debounced rising edge becomes a one-cycle S or R pulse. S and R are never
// high together. Because the flip-flop has no reset of its own, one R pulse
// is issued right after reset.
module sr_cmd_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_set,
  input  logic btn_clr,
  output logic S,
  output logic R,
  output logic conflict,
  output logic sr_state
);

  // Channel indices into the per-channel vectors below.
  localparam int CH_SET = 0;
  localparam int CH_CLR = 1;

  // Last counter value before the debounced level is allowed to follow s2.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Raw button inputs, packed by channel index.
  logic [1:0] btn;
  assign btn = {btn_clr, btn_set};

  // Per-channel pipeline: synchroniser, debounced level, delayed level.
  logic [1:0] s1_q, s1_d;
  logic [1:0] s2_q, s2_d;
  logic [1:0] db_q, db_d;
  logic [1:0] db_prev_q, db_prev_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Press events: rising edge of the debounced level only.
  logic [1:0] evt;

  // Control FSM and registered outputs.
  state_e state_q, state_d;
  logic   s_q, s_d;
  logic   r_q, r_d;
  logic   conflict_q, conflict_d;
  logic   sr_state_q, sr_state_d;

  // Synchroniser shift and debounce counters for both channels.
  always_comb begin
    s1_d      = btn;
    s2_d      = s1_q;
    db_prev_d = db_q;
    db_d      = db_q;
    cnt_d     = '0;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign evt = db_q & ~db_prev_q;

  // Next-state and pulse generation; a same-edge set/clear pair is dropped.
  always_comb begin
    state_d    = state_q;
    s_d        = 1'b0;
    r_d        = 1'b0;
    conflict_d = 1'b0;
    sr_state_d = sr_state_q;
    if (s_q) begin
      sr_state_d = 1'b1;
    end else if (r_q) begin
      sr_state_d = 1'b0;
    end
    case (state_q)
      ST_INIT: begin
        r_d     = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        s_d        = evt[CH_SET] & ~evt[CH_CLR];
        r_d        = evt[CH_CLR] & ~evt[CH_SET];
        conflict_d = evt[CH_SET] &  evt[CH_CLR];
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      db_q       <= '0;
      db_prev_q  <= '0;
      cnt_q      <= '0;
      state_q    <= ST_INIT;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
      sr_state_q <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      db_q       <= db_d;
      db_prev_q  <= db_prev_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      s_q        <= s_d;
      r_q        <= r_d;
      conflict_q <= conflict_d;
      sr_state_q <= sr_state_d;
    end
  end

  assign S        = s_q;
  assign R        = r_q;
  assign conflict = conflict_q;
  assign sr_state = sr_state_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Testbench for sr_cmd_gen: directed scenarios on a D=4 instance plus a
// randomised run on D=1 and D=7 instances checked against a cycle model.
module tb_sr_cmd_gen;

  logic clk = 1'b0;
  logic rst_n, btn_set, btn_clr;
  logic s_o, r_o, conflict_o, sr_o;

  logic       rrst_n;
  logic [1:0] rset, rclr, rs, rr, rcf, rsr;

  int tests_run    = 0;
  int tests_failed = 0;

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  sr_cmd_gen #(.DEBOUNCE_CYCLES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .btn_set(btn_set), .btn_clr(btn_clr),
    .S(s_o), .R(r_o), .conflict(conflict_o), .sr_state(sr_o)
  );

  sr_cmd_gen #(.DEBOUNCE_CYCLES(1)) u_d1 (
    .clk(clk), .rst_n(rrst_n), .btn_set(rset[0]), .btn_clr(rclr[0]),
    .S(rs[0]), .R(rr[0]), .conflict(rcf[0]), .sr_state(rsr[0])
  );

  sr_cmd_gen #(.DEBOUNCE_CYCLES(7)) u_d7 (
    .clk(clk), .rst_n(rrst_n), .btn_set(rset[1]), .btn_clr(rclr[1]),
    .S(rs[1]), .R(rr[1]), .conflict(rcf[1]), .sr_state(rsr[1])
  );

  // Reference model state for the two random instances, indexed [inst][chan].
  bit m_s1 [2][2];
  bit m_s2 [2][2];
  bit m_db [2][2];
  bit m_dbp[2][2];
  int m_cnt[2][2];
  bit m_S[2], m_R[2], m_cf[2], m_sr[2], m_init[2];

  // Advance one edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Clock edge of the model: all right-hand sides use pre-edge values.
  task automatic model_step(input int k, input int d, input bit rst, input bit bs, input bit bc);
    bit se, ce, b;
    se = m_db[k][0] & ~m_dbp[k][0];
    ce = m_db[k][1] & ~m_dbp[k][1];
    if (!rst) begin
      for (int c = 0; c < 2; c++) begin
        m_s1[k][c] = 0; m_s2[k][c] = 0; m_db[k][c] = 0; m_dbp[k][c] = 0; m_cnt[k][c] = 0;
      end
      m_S[k] = 0; m_R[k] = 0; m_cf[k] = 0; m_sr[k] = 0; m_init[k] = 1;
    end else begin
      if (m_S[k]) m_sr[k] = 1;
      else if (m_R[k]) m_sr[k] = 0;
      if (m_init[k]) begin
        m_S[k] = 0; m_R[k] = 1; m_cf[k] = 0; m_init[k] = 0;
      end else begin
        m_S[k] = se & ~ce; m_R[k] = ce & ~se; m_cf[k] = se & ce;
      end
      for (int c = 0; c < 2; c++) begin
        b = (c == 0) ? bs : bc;
        m_dbp[k][c] = m_db[k][c];
        if (m_s2[k][c] == m_db[k][c]) m_cnt[k][c] = 0;
        else if (m_cnt[k][c] == d - 1) begin
          m_db[k][c] = m_s2[k][c]; m_cnt[k][c] = 0;
        end else m_cnt[k][c] = m_cnt[k][c] + 1;
        m_s2[k][c] = m_s1[k][c];
        m_s1[k][c] = b;
      end
    end
  endtask

  // Reset held for 3 edges, then released: one init R pulse, nothing else.
  task automatic test_reset();
    rst_n = 0; btn_set = 0; btn_clr = 0;
    for (int j = 0; j < 3; j++) begin
      tick();
      tests_run++;
      if ({s_o, r_o, conflict_o, sr_o} !== 4'b0000) begin
        tests_failed++;
        $display("[TB] FAIL reset_hold j=%0d got S,R,cf,sr=%b%b%b%b exp 0000", j, s_o, r_o, conflict_o, sr_o);
      end
    end
    rst_n = 1;
    for (int j = 0; j < 5; j++) begin
      tick();
      tests_run++;
      if (r_o !== (j == 0)) begin
        tests_failed++;
        $display("[TB] FAIL reset_init_R j=%0d got %b exp %b", j, r_o, (j == 0));
      end
      tests_run++;
      if ({s_o, conflict_o, sr_o} !== 3'b000) begin
        tests_failed++;
        $display("[TB] FAIL reset_others j=%0d got S,cf,sr=%b%b%b exp 000", j, s_o, conflict_o, sr_o);
      end
    end
  endtask

  // Set held for 21 edges: S after E6 only, sr_state from E7.
  task automatic test_clean_press();
    btn_set = 1;
    for (int j = 0; j <= 20; j++) begin
      tick();
      tests_run++;
      if (s_o !== (j == 6)) begin
        tests_failed++;
        $display("[TB] FAIL press_S j=%0d got %b exp %b", j, s_o, (j == 6));
      end
      tests_run++;
      if (sr_o !== (j >= 7)) begin
        tests_failed++;
        $display("[TB] FAIL press_sr j=%0d got %b exp %b", j, sr_o, (j >= 7));
      end
      tests_run++;
      if ({r_o, conflict_o} !== 2'b00) begin
        tests_failed++;
        $display("[TB] FAIL press_R_cf j=%0d got %b%b exp 00", j, r_o, conflict_o);
      end
    end
    btn_set = 0;
    for (int j = 0; j < 12; j++) begin
      tick();
      tests_run++;
      if ({s_o, r_o, sr_o} !== 3'b001) begin
        tests_failed++;
        $display("[TB] FAIL release_quiet j=%0d got S,R,sr=%b%b%b exp 001", j, s_o, r_o, sr_o);
      end
    end
  endtask

  // Clear bounces with 3-cycle widths, then settles high at E12: R after E18.
  task automatic test_bounce();
    for (int j = 0; j <= 24; j++) begin
      btn_clr = (j < 12) ? (((j / 3) % 2) == 0) : 1'b1;
      tick();
      tests_run++;
      if (r_o !== (j == 18)) begin
        tests_failed++;
        $display("[TB] FAIL bounce_R j=%0d got %b exp %b", j, r_o, (j == 18));
      end
      tests_run++;
      if (sr_o !== (j < 19)) begin
        tests_failed++;
        $display("[TB] FAIL bounce_sr j=%0d got %b exp %b", j, sr_o, (j < 19));
      end
      tests_run++;
      if (s_o !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL bounce_S j=%0d got %b exp 0", j, s_o);
      end
    end
    btn_clr = 0;
    for (int j = 0; j < 12; j++) tick();
  endtask

  // Both pressed on the same edge: conflict after E6, no pulses; then set alone.
  task automatic test_simultaneous();
    btn_set = 1; btn_clr = 1;
    for (int j = 0; j <= 15; j++) begin
      tick();
      tests_run++;
      if (conflict_o !== (j == 6)) begin
        tests_failed++;
        $display("[TB] FAIL simul_cf j=%0d got %b exp %b", j, conflict_o, (j == 6));
      end
      tests_run++;
      if ({s_o, r_o, sr_o} !== 3'b000) begin
        tests_failed++;
        $display("[TB] FAIL simul_pulses j=%0d got S,R,sr=%b%b%b exp 000", j, s_o, r_o, sr_o);
      end
    end
    btn_set = 0; btn_clr = 0;
    for (int j = 0; j < 12; j++) tick();
    btn_set = 1;
    for (int j = 0; j <= 9; j++) begin
      tick();
      tests_run++;
      if (s_o !== (j == 6) || sr_o !== (j >= 7)) begin
        tests_failed++;
        $display("[TB] FAIL simul_after j=%0d got S,sr=%b%b exp %b%b", j, s_o, sr_o, (j == 6), (j >= 7));
      end
    end
    btn_set = 0;
    for (int j = 0; j < 12; j++) tick();
  endtask

  // Reset while set is mid-debounce (cnt=2), button still held afterwards.
  task automatic test_reset_mid();
    btn_set = 1;
    for (int j = 0; j < 4; j++) begin
      tick();
      tests_run++;
      if (s_o !== 1'b0 || sr_o !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL mid_pre j=%0d got S,sr=%b%b exp 01", j, s_o, sr_o);
      end
    end
    rst_n = 0;
    for (int j = 0; j < 2; j++) begin
      tick();
      tests_run++;
      if ({s_o, r_o, conflict_o, sr_o} !== 4'b0000) begin
        tests_failed++;
        $display("[TB] FAIL mid_reset j=%0d got S,R,cf,sr=%b%b%b%b exp 0000", j, s_o, r_o, conflict_o, sr_o);
      end
    end
    rst_n = 1;
    for (int j = 0; j <= 10; j++) begin
      tick();
      tests_run++;
      if (r_o !== (j == 0)) begin
        tests_failed++;
        $display("[TB] FAIL mid_R j=%0d got %b exp %b", j, r_o, (j == 0));
      end
      tests_run++;
      if (s_o !== (j == 6) || sr_o !== (j >= 7)) begin
        tests_failed++;
        $display("[TB] FAIL mid_S j=%0d got S,sr=%b%b exp %b%b", j, s_o, sr_o, (j == 6), (j >= 7));
      end
    end
    btn_set = 0;
    for (int j = 0; j < 12; j++) tick();
  endtask

  // Set at E0, clear at E1: S after E6 then R after E7, both honoured.
  task automatic test_back_to_back();
    for (int j = 0; j <= 12; j++) begin
      if (j == 0) btn_set = 1;
      if (j == 1) btn_clr = 1;
      tick();
      tests_run++;
      if (s_o !== (j == 6) || r_o !== (j == 7)) begin
        tests_failed++;
        $display("[TB] FAIL b2b_pulses j=%0d got S,R=%b%b exp %b%b", j, s_o, r_o, (j == 6), (j == 7));
      end
      tests_run++;
      if (sr_o !== (j < 8) || conflict_o !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL b2b_sr j=%0d got sr,cf=%b%b exp %b0", j, sr_o, conflict_o, (j < 8));
      end
    end
    btn_set = 0; btn_clr = 0;
    for (int j = 0; j < 12; j++) tick();
  endtask

  // Random buttons on D=1 and D=7 instances against the cycle model.
  task automatic test_random();
    int   dv[2];
    logic prev_s[2], prev_r[2];
    dv[0] = 1; dv[1] = 7;
    prev_s[0] = 0; prev_s[1] = 0; prev_r[0] = 0; prev_r[1] = 0;
    rrst_n = 0; rset = '0; rclr = '0;
    for (int n = 0; n < 10002; n++) begin
      rrst_n = (n < 2) ? 1'b0 : ($urandom_range(0, 999) != 0);
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, (k == 0) ? 2 : 5) == 0) rset[k] = ~rset[k];
        if ($urandom_range(0, (k == 0) ? 2 : 5) == 0) rclr[k] = ~rclr[k];
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) model_step(k, dv[k], rrst_n, rset[k], rclr[k]);
      #1;
      for (int k = 0; k < 2; k++) begin
        tests_run++;
        if (rs[k] !== m_S[k] || rr[k] !== m_R[k] || rcf[k] !== m_cf[k] || rsr[k] !== m_sr[k]) begin
          tests_failed++;
          $display("[TB] FAIL random_model D=%0d n=%0d got S,R,cf,sr=%b%b%b%b exp %b%b%b%b", dv[k], n, rs[k], rr[k], rcf[k], rsr[k], m_S[k], m_R[k], m_cf[k], m_sr[k]);
        end
        tests_run++;
        if ((rs[k] & rr[k]) !== 1'b0 || (rs[k] & prev_s[k]) !== 1'b0 || (rr[k] & prev_r[k]) !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL random_invariant D=%0d n=%0d got S,R=%b%b prev %b%b exp no overlap", dv[k], n, rs[k], rr[k], prev_s[k], prev_r[k]);
        end
        prev_s[k] = rs[k];
        prev_r[k] = rr[k];
      end
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    rst_n = 0; btn_set = 0; btn_clr = 0;
    rrst_n = 0; rset = '0; rclr = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
